// File: rtl/wb_xbar_nxm.sv
// rtl/wb_xbar_nxm.sv - N-master x M-slave Wishbone classic crossbar with round-robin arbitration
//
// Purpose:
//   NUM_MASTERS masters share NUM_SLAVES peripherals through one round-robin arbiter.
//   A granted master keeps the bus for as long as it holds cyc, so locked block
//   transfers are never preempted. Slaves are selected by a base/mask table.
//   Accesses that hit no slave, and slaves that hold stb without ack for TIMEOUT
//   cycles, are terminated with a one-cycle bus error.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i       per-master controls (NUM_MASTERS bits each)
//   m_adr_i/m_dat_i              per-master address / write data (NUM_MASTERS*32)
//   m_sel_i                      per-master byte selects (NUM_MASTERS*4)
//   m_dat_o                      per-master read data (NUM_MASTERS*32)
//   m_ack_o/m_err_o              per-master ack / error
//   s_cyc_o/s_stb_o/s_we_o       per-slave controls (NUM_SLAVES bits each)
//   s_adr_o/s_dat_o/s_sel_o      shared address / write data / byte selects
//   s_dat_i/s_ack_i              per-slave read data / ack
//   err_irq_o                    one-cycle pulse per bus error
//   err_addr_o                   address of the last errored access
//   busy_o                       a master currently holds the grant

module wb_xbar_nxm #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 8,
    // Default table places slave i at i<<24; override together with NUM_SLAVES.
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = {
        32'h0700_0000, 32'h0600_0000, 32'h0500_0000, 32'h0400_0000,
        32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {NUM_SLAVES{32'hFF00_0000}},
    parameter int TIMEOUT = 256,
    parameter logic [31:0] ERR_DATA = 32'hBADC_0FFE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*32-1:0] m_adr_i,
    input  logic [NUM_MASTERS*32-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    output logic [NUM_MASTERS*32-1:0] m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_SLAVES-1:0]     s_cyc_o,
    output logic [NUM_SLAVES-1:0]     s_stb_o,
    output logic [NUM_SLAVES-1:0]     s_we_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    input  logic [NUM_SLAVES*32-1:0]  s_dat_i,
    input  logic [NUM_SLAVES-1:0]     s_ack_i,
    output logic                      err_irq_o,
    output logic [31:0]               err_addr_o,
    output logic                      busy_o
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;      // first master to consider on the next arbitration
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     err_addr_q, err_addr_d;

    // Granted master's request, selected by the registered grant index.
    logic            g_cyc, g_stb, g_we;
    logic [31:0]     g_adr, g_dat;
    logic [3:0]      g_sel;

    always_comb begin
        g_cyc = m_cyc_i[grant_q];
        g_stb = m_stb_i[grant_q];
        g_we  = m_we_i[grant_q];
        g_adr = m_adr_i[{grant_q, 5'b0} +: 32];
        g_dat = m_dat_i[{grant_q, 5'b0} +: 32];
        g_sel = m_sel_i[{grant_q, 2'b0} +: 4];
    end

    // Address decode: scanning from the top down lets the lowest matching index win.
    logic            hit;
    logic [SW-1:0]   hit_idx;
    logic            hit_ack;
    logic [31:0]     hit_dat;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((g_adr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
        hit_ack = hit & s_ack_i[hit_idx];
        hit_dat = s_dat_i[{hit_idx, 5'b0} +: 32];
    end

    // Round-robin pick among masters asserting cyc, starting at ptr_q.
    logic            arb_found;
    logic [GW-1:0]   arb_idx;
    int              arb_pos;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_pos   = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            arb_pos = int'(ptr_q) + k;
            if (arb_pos >= NUM_MASTERS) begin
                arb_pos = arb_pos - NUM_MASTERS;
            end
            if (!arb_found && m_cyc_i[arb_pos]) begin
                arb_found = 1'b1;
                arb_idx   = GW'(arb_pos);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        err_addr_d = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!g_cyc) begin
                    // Release: cancels any pending timeout; next scan starts after this master.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ptr_d   = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);
                end else if (g_stb && !hit) begin
                    state_d    = ST_ERR;
                    err_addr_d = g_adr;
                    cnt_d      = '0;
                end else if (g_stb && !hit_ack) begin
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d    = ST_ERR;
                        err_addr_d = g_adr;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_ERR: begin
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Output routing. Slave controls exist only in BUSY, so they drop in ERR and IDLE;
    // slave acks outside BUSY, or from a slave that is not addressed, are ignored.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (state_q != ST_IDLE) begin
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
        end
        if (state_q == ST_BUSY && g_cyc && hit) begin
            s_cyc_o[hit_idx]                = 1'b1;
            s_stb_o[hit_idx]                = g_stb;
            s_we_o[hit_idx]                 = g_we;
            m_ack_o[grant_q]                = g_stb & hit_ack;
            m_dat_o[{grant_q, 5'b0} +: 32]  = hit_dat;
        end
        if (state_q == ST_ERR) begin
            m_err_o[grant_q]                = 1'b1;
            m_dat_o[{grant_q, 5'b0} +: 32]  = ERR_DATA;
        end
    end

    assign err_irq_o  = (state_q == ST_ERR);
    assign err_addr_o = err_addr_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_xbar_nxm.sv
// tb/tb_wb_xbar_nxm.sv - directed self-checking bench for wb_xbar_nxm

module tb_wb_xbar_nxm;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [63:0]  m_adr_i, m_dat_i;
    logic [7:0]   m_sel_i;
    logic [63:0]  m_dat_o;
    logic [1:0]   m_ack_o, m_err_o;
    logic [7:0]   s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [3:0]   s_sel_o;
    logic [255:0] s_dat_i;
    logic [7:0]   s_ack_i;
    logic         err_irq_o;
    logic [31:0]  err_addr_o;
    logic         busy_o;

    int vectors = 0;
    int miscompares = 0;

    wb_xbar_nxm #(.NUM_MASTERS(2), .NUM_SLAVES(8), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .err_irq_o(err_irq_o), .err_addr_o(err_addr_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = '0; s_ack_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        vectors++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin miscompares++; $display("FAIL reset_ack_err got %b/%b want 00/00", m_ack_o, m_err_o); end
        vectors++; if (s_stb_o !== 8'h00 || s_cyc_o !== 8'h00) begin miscompares++; $display("FAIL reset_slv got %h/%h want 00/00", s_stb_o, s_cyc_o); end
        vectors++; if (m_dat_o !== 64'h0 || err_addr_o !== 32'h0 || err_irq_o !== 1'b0) begin miscompares++; $display("FAIL reset_data got %h %h %b want 0", m_dat_o, err_addr_o, err_irq_o); end
    endtask

    task automatic test_read();
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[31:0] = 32'h0300_0010; m_sel_i[3:0] = 4'hF;
        #1;
        vectors++; if (busy_o !== 1'b0 || s_stb_o !== 8'h00) begin miscompares++; $display("FAIL read_pregrant got busy=%b stb=%h want 0/00", busy_o, s_stb_o); end
        step();
        #1;
        vectors++; if (s_stb_o !== 8'h08 || s_cyc_o !== 8'h08) begin miscompares++; $display("FAIL read_decode got stb=%h cyc=%h want 08/08", s_stb_o, s_cyc_o); end
        vectors++; if (s_adr_o !== 32'h0300_0010 || s_sel_o !== 4'hF) begin miscompares++; $display("FAIL read_adr got %h/%h want 03000010/f", s_adr_o, s_sel_o); end
        vectors++; if (m_ack_o !== 2'b00) begin miscompares++; $display("FAIL read_noack got %b want 00", m_ack_o); end
        step();
        s_ack_i[3] = 1'b1; s_dat_i[3*32 +: 32] = 32'h1234_5678;
        #1;
        vectors++; if (m_ack_o !== 2'b01) begin miscompares++; $display("FAIL read_ack got %b want 01", m_ack_o); end
        vectors++; if (m_dat_o[31:0] !== 32'h1234_5678) begin miscompares++; $display("FAIL read_data got %h want 12345678", m_dat_o[31:0]); end
        step();
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_arbitration();
        do_reset();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        m_adr_i = {32'h0500_0000, 32'h0100_0000};
        step();
        #1;
        vectors++; if (s_stb_o !== 8'h02) begin miscompares++; $display("FAIL arb_first got %h want 02", s_stb_o); end
        m_cyc_i[0] = 1'b0; m_stb_i[0] = 1'b0;
        step();
        #1;
        vectors++; if (busy_o !== 1'b0 || s_stb_o !== 8'h00) begin miscompares++; $display("FAIL arb_idle_gap got busy=%b stb=%h want 0/00", busy_o, s_stb_o); end
        step();
        #1;
        vectors++; if (s_stb_o !== 8'h20 || busy_o !== 1'b1) begin miscompares++; $display("FAIL arb_second got stb=%h busy=%b want 20/1", s_stb_o, busy_o); end
        clear_inputs();
        step();
        // Pointer is back at 0: M0 alone takes and releases the bus, moving it to 1.
        m_cyc_i = 2'b01;
        step();
        m_cyc_i = 2'b00;
        step();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        m_adr_i = {32'h0500_0000, 32'h0100_0000};
        step();
        #1;
        vectors++; if (s_stb_o !== 8'h20) begin miscompares++; $display("FAIL arb_ptr1 got %h want 20", s_stb_o); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_unmapped();
        do_reset();
        m_cyc_i[1] = 1'b1; m_stb_i[1] = 1'b1; m_we_i[1] = 1'b1;
        m_adr_i[63:32] = 32'hF000_0000; m_dat_i[63:32] = 32'hDEAD_BEEF;
        step();
        #1;
        vectors++; if (s_stb_o !== 8'h00 || s_we_o !== 8'h00 || m_err_o !== 2'b00) begin miscompares++; $display("FAIL unmap_busy got stb=%h we=%h err=%b want 00/00/00", s_stb_o, s_we_o, m_err_o); end
        vectors++; if (s_dat_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL unmap_wdata got %h want deadbeef", s_dat_o); end
        step();
        #1;
        vectors++; if (m_err_o !== 2'b10 || m_ack_o !== 2'b00) begin miscompares++; $display("FAIL unmap_err got err=%b ack=%b want 10/00", m_err_o, m_ack_o); end
        vectors++; if (m_dat_o[63:32] !== 32'hBADC_0FFE) begin miscompares++; $display("FAIL unmap_errdata got %h want badc0ffe", m_dat_o[63:32]); end
        vectors++; if (err_irq_o !== 1'b1 || err_addr_o !== 32'hF000_0000) begin miscompares++; $display("FAIL unmap_irq got irq=%b addr=%h want 1/f0000000", err_irq_o, err_addr_o); end
        vectors++; if (s_stb_o !== 8'h00) begin miscompares++; $display("FAIL unmap_nostb got %h want 00", s_stb_o); end
        clear_inputs();
        step();
        #1;
        vectors++; if (err_irq_o !== 1'b0 || m_err_o !== 2'b00) begin miscompares++; $display("FAIL unmap_pulse got irq=%b err=%b want 0/00", err_irq_o, m_err_o); end
        step();
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[31:0] = 32'h0200_0000;
        step();
        for (int k = 0; k < 8; k++) begin
            #1;
            vectors++; if (s_stb_o !== 8'h04 || m_err_o !== 2'b00) begin miscompares++; $display("FAIL tmo_wait%0d got stb=%h err=%b want 04/00", k, s_stb_o, m_err_o); end
            step();
        end
        #1;
        vectors++; if (m_err_o !== 2'b01 || s_stb_o !== 8'h00) begin miscompares++; $display("FAIL tmo_err got err=%b stb=%h want 01/00", m_err_o, s_stb_o); end
        vectors++; if (err_addr_o !== 32'h0200_0000 || m_dat_o[31:0] !== 32'hBADC_0FFE) begin miscompares++; $display("FAIL tmo_info got addr=%h dat=%h want 02000000/badc0ffe", err_addr_o, m_dat_o[31:0]); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_cyc_i = 2'b11; m_stb_i = 2'b10; m_adr_i[63:32] = 32'h0100_0000;
        step();
        for (int b = 0; b < 4; b++) begin
            m_stb_i[0] = 1'b1; m_adr_i[31:0] = 32'h0600_0000 + 32'(b * 4);
            s_ack_i[6] = 1'b1; s_dat_i[6*32 +: 32] = 32'hA000_0000 + 32'(b);
            #1;
            vectors++; if (m_ack_o !== 2'b01 || s_stb_o !== 8'h40) begin miscompares++; $display("FAIL b2b_beat%0d got ack=%b stb=%h want 01/40", b, m_ack_o, s_stb_o); end
            vectors++; if (m_dat_o[31:0] !== 32'hA000_0000 + 32'(b)) begin miscompares++; $display("FAIL b2b_data%0d got %h want %h", b, m_dat_o[31:0], 32'hA000_0000 + 32'(b)); end
            step();
        end
        m_stb_i[0] = 1'b0; s_ack_i[6] = 1'b0;
        #1;
        vectors++; if (busy_o !== 1'b1 || s_stb_o !== 8'h00 || m_ack_o !== 2'b00) begin miscompares++; $display("FAIL b2b_hold got busy=%b stb=%h ack=%b want 1/00/00", busy_o, s_stb_o, m_ack_o); end
        step();
        m_cyc_i[0] = 1'b0;
        step();
        #1;
        vectors++; if (busy_o !== 1'b0 || m_ack_o !== 2'b00) begin miscompares++; $display("FAIL b2b_gap got busy=%b ack=%b want 0/00", busy_o, m_ack_o); end
        step();
        s_ack_i[1] = 1'b1;
        #1;
        vectors++; if (s_stb_o !== 8'h02 || m_ack_o !== 2'b10) begin miscompares++; $display("FAIL b2b_m1 got stb=%h ack=%b want 02/10", s_stb_o, m_ack_o); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_reset_abort();
        do_reset();
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[31:0] = 32'h0400_0000;
        step();
        #1;
        vectors++; if (s_stb_o !== 8'h10) begin miscompares++; $display("FAIL abort_pre got %h want 10", s_stb_o); end
        rst_i = 1'b1;
        step();
        s_ack_i[4] = 1'b1; s_dat_i[4*32 +: 32] = 32'h5555_AAAA;
        #1;
        vectors++; if (busy_o !== 1'b0 || s_stb_o !== 8'h00 || s_cyc_o !== 8'h00) begin miscompares++; $display("FAIL abort_idle got busy=%b stb=%h cyc=%h want 0/00/00", busy_o, s_stb_o, s_cyc_o); end
        vectors++; if (m_ack_o !== 2'b00 || m_err_o !== 2'b00 || m_dat_o !== 64'h0 || err_irq_o !== 1'b0) begin miscompares++; $display("FAIL abort_late_ack got ack=%b err=%b dat=%h irq=%b want 0", m_ack_o, m_err_o, m_dat_o, err_irq_o); end
        rst_i = 1'b0;
        clear_inputs();
        step();
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_read();
        test_arbitration();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_xbar_nxm.md
Name: wb_xbar_nxm

Overview:
Parametrised Wishbone (classic, 32-bit) interconnect. Successor to the fixed single-master crossbar: NUM_MASTERS masters (CPU, DMA, debug) share NUM_SLAVES peripherals through one round-robin arbiter. A parameter table decodes slave addresses. Unmapped accesses and hung slaves are terminated with a bus error. Sits between the core/DMA masters and the peripheral set (uart, spi, pwm, sram, timer, i2c, efpga).

Parameters:
NUM_MASTERS, 2, number of master ports (1..4)
NUM_SLAVES, 8, number of slave ports (1..16)
SLV_BASE, {i<<24 for i=0..NUM_SLAVES-1}, packed NUM_SLAVES*32 base addresses
SLV_MASK, all 32'hFF00_0000, packed NUM_SLAVES*32 decode masks
TIMEOUT, 256, cycles a slave may hold stb without ack before error (>=2)
ERR_DATA, 32'hBADC_0FFE, read data returned on error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m_cyc_i/m_stb_i/m_we_i  in  NUM_MASTERS each  per-master Wishbone controls
m_adr_i/m_dat_i  in  NUM_MASTERS*32  per-master address / write data
m_sel_i  in  NUM_MASTERS*4  per-master byte selects
m_dat_o  out  NUM_MASTERS*32  per-master read data
m_ack_o/m_err_o  out  NUM_MASTERS each  per-master ack / error
s_cyc_o/s_stb_o/s_we_o  out  NUM_SLAVES each  per-slave controls
s_adr_o/s_dat_o  out  32  shared address / write data to all slaves
s_sel_o  out  4  shared byte selects
s_dat_i  in  NUM_SLAVES*32  per-slave read data
s_ack_i  in  NUM_SLAVES  per-slave ack
err_irq_o  out  1  one-cycle pulse per bus error
err_addr_o  out  32  address of last errored access
busy_o  out  1  grant held

Behaviour:
- One clock (clk_i); reset synchronous, active-high (rst_i). Reset: state IDLE, no grant, RR pointer=0, timeout cnt=0. All m_ack_o, m_err_o, s_cyc_o, s_stb_o, err_irq_o, busy_o = 0. m_dat_o=0, err_addr_o=0. Reset mid-transaction aborts without ack/err.
- FSM IDLE/BUSY/ERR.
- IDLE: if any m_cyc_i, grant the first requester scanning from (last_grant+1) mod NUM_MASTERS. Grant registered; go BUSY. Latency: grant is visible 1 cycle after cyc.
- BUSY: granted master's adr/dat/sel/we drive s_*_o. Decode is combinational on the granted adr: hit if (adr & SLV_MASK[i]) == SLV_BASE[i]; lowest index wins on overlap.
  - s_cyc_o/s_stb_o asserted only on the hit slave.
  - Hit slave's s_ack_i/s_dat_i route combinationally to granted master; zero-latency pass-through.
  - Non-granted masters: ack=err=0, dat=0. Slave acks without a grant are ignored.
- Decode miss with stb high -> ERR next cycle; no slave sees stb.
- Timeout: cnt increments while granted stb high and no ack; clears on ack or stb low. When cnt==TIMEOUT-1 without ack -> ERR. s_stb_o/s_cyc_o drop in ERR.
- ERR (1 cycle): m_err_o=1, m_dat_o=ERR_DATA to granted master, err_irq_o=1, err_addr_o latched. Then return to BUSY.
- Granted master drops m_cyc_i in BUSY -> IDLE next cycle; last_grant updated. Any pending timeout or error is cancelled.
- Grant held across consecutive stb beats while cyc stays high (locked block transfers). Other masters wait; no preemption.
- Simultaneous requests: the RR pointer decides. Same-cycle cyc drop and new request: the new grant comes only after one IDLE cycle.
- ack and err are never both asserted. busy_o = (state != IDLE).

Test Plan:
- M0 reads 0x0300_0010, slave3 acks next cycle with 0x1234_5678 -> m_dat_o[M0]=0x1234_5678, m_ack_o[0]=1; only s_stb_o[3] asserted.
- M0 and M1 assert cyc in the same cycle from reset -> M0 granted first; M0 drops cyc; M1 granted after one IDLE cycle. Repeat -> M1 wins when pointer=1.
- M1 writes 0xF000_0000 (unmapped) -> no s_stb_o. m_err_o[1]=1 two cycles after cyc, dat=0xBADC_0FFE. err_irq_o pulses; err_addr_o=0xF000_0000.
- Slave2 never acks, TIMEOUT=8 -> err after 8 BUSY stb cycles; s_stb_o[2] drops in the ERR cycle.
- M0 holds cyc for 4 back-to-back stb beats while M1 requests -> M1 blocked until M0 cyc low; no M1 ack during the burst.
- rst_i asserted during slave4 wait -> next cycle all outputs 0, busy_o=0; a late s_ack_i[4] produces no m_ack_o.
